// File: rtl/fetch.sv
// fetch: RV32I program counter and in-order instruction-memory reader feeding decode.
// Latency: I_VALID the cycle after MEM_RVALID; backpressure: STALL holds the head, credits throttle MEM_REQ.
module fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_ADDR,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] I_PC,
  output logic        I_VALID,
  output logic [31:0] I_INST
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_t;

  logic [31:0] pc;
  logic [31:0] br_tgt;

  ibuf_t       ibuf [2];
  logic        ib_wr;
  logic        ib_rd;
  logic [1:0]  fifo_cnt;
  ibuf_t       head;

  logic [31:0] rq_pc [2];
  logic        rq_wr;
  logic        rq_rd;
  logic [1:0]  out_cnt;
  logic [1:0]  disc_cnt;

  logic        mem_acc;
  logic        ib_push;
  logic        ib_pop;

  assign br_tgt   = BR_ADDR & 32'hFFFF_FFFC;

  // Buffered plus in-flight words never exceed the two buffer slots.
  assign MEM_REQ  = RST && !BR_TAKEN && (({1'b0, fifo_cnt} + {1'b0, out_cnt}) < 3'd2);
  assign MEM_ADDR = pc;
  assign mem_acc  = MEM_REQ && MEM_READY;

  assign ib_push  = MEM_RVALID && (disc_cnt == 2'd0) && !BR_TAKEN;
  assign ib_pop   = I_VALID && !STALL;

  assign head     = ibuf[ib_rd];
  assign I_VALID  = (fifo_cnt != 2'd0);
  assign I_PC     = I_VALID ? head.pc   : 32'd0;
  assign I_INST   = I_VALID ? head.inst : 32'd0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc       <= START_ADDR;
      ib_wr    <= 1'b0;
      ib_rd    <= 1'b0;
      fifo_cnt <= 2'd0;
      rq_wr    <= 1'b0;
      rq_rd    <= 1'b0;
      out_cnt  <= 2'd0;
      disc_cnt <= 2'd0;
    end else begin
      // The request queue tracks every in-flight read, including ones to be discarded.
      if (mem_acc)    rq_wr <= ~rq_wr;
      if (MEM_RVALID) rq_rd <= ~rq_rd;
      out_cnt <= out_cnt + {1'b0, mem_acc} - {1'b0, MEM_RVALID};

      if (BR_TAKEN) begin
        pc       <= br_tgt;
        disc_cnt <= out_cnt - {1'b0, MEM_RVALID};
        ib_wr    <= 1'b0;
        ib_rd    <= 1'b0;
        fifo_cnt <= 2'd0;
      end else begin
        if (mem_acc) pc <= pc + 32'd4;
        if (MEM_RVALID && (disc_cnt != 2'd0)) disc_cnt <= disc_cnt - 2'd1;
        if (ib_push) ib_wr <= ~ib_wr;
        if (ib_pop)  ib_rd <= ~ib_rd;
        if (ib_push && !ib_pop)      fifo_cnt <= fifo_cnt + 2'd1;
        else if (ib_pop && !ib_push) fifo_cnt <= fifo_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_acc) rq_pc[rq_wr] <= pc;
    if (ib_push) ibuf[ib_wr]  <= {rq_pc[rq_rd], MEM_RDATA};
  end

  a_rsp_has_req: assert property (@(posedge CLK) disable iff (!RST) MEM_RVALID |-> (out_cnt != 2'd0));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: streaming, stall, redirect, memory backpressure and mid-stream reset
// against a queued instruction-memory model returning addr ^ 32'hA5A5_0000.
module tb_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_ADDR = 32'd0;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_READY = 1'b1;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic [31:0] I_PC;
  logic        I_VALID;
  logic [31:0] I_INST;

  bit          rsp_en = 1'b1;
  logic [31:0] mq[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  int          n_tests = 0;
  int          n_fail = 0;

  fetch #(.START_ADDR(32'h0000_0000)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .STALL     (STALL),
    .BR_TAKEN  (BR_TAKEN),
    .BR_ADDR   (BR_ADDR),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_READY (MEM_READY),
    .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA (MEM_RDATA),
    .I_PC      (I_PC),
    .I_VALID   (I_VALID),
    .I_INST    (I_INST)
  );

  always #5 CLK = ~CLK;

  // Memory answers the oldest accepted request whenever rsp_en is set; reset drops everything.
  always @(posedge CLK) begin
    if (!RST) begin
      mq.delete();
      MEM_RVALID <= 1'b0;
      MEM_RDATA  <= 32'd0;
    end else begin
      if (MEM_REQ && MEM_READY) begin
        mq.push_back(MEM_ADDR);
        acc_q.push_back(MEM_ADDR);
      end
      if (rsp_en && mq.size() != 0) begin
        MEM_RVALID <= 1'b1;
        MEM_RDATA  <= mq.pop_front() ^ KEY;
      end else begin
        MEM_RVALID <= 1'b0;
        MEM_RDATA  <= 32'd0;
      end
      if (I_VALID && !STALL && !BR_TAKEN) begin
        pop_pc.push_back(I_PC);
        pop_inst.push_back(I_INST);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    cyc();
    RST = 1'b1;
    acc_q.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  // Consumed instructions must be base, base+4, ... with matching words.
  task automatic chk_seq(input string tag, input int n, input logic [31:0] base);
    logic [31:0] e;
    for (int i = 0; i < 200; i++) begin
      if (pop_pc.size() >= n) break;
      cyc();
    end
    chk({tag, "_cnt"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      e = base + 32'(4 * i);
      chk({tag, "_pc"},   (i < pop_pc.size())   ? pop_pc[i]   : 32'hDEAD_BEEF, e);
      chk({tag, "_inst"}, (i < pop_inst.size()) ? pop_inst[i] : 32'hDEAD_BEEF, e ^ KEY);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held across two edges; outputs checked while still in reset.
    cyc();
    chk("rst_vld",  32'(I_VALID), 32'd0);
    chk("rst_pc",   I_PC, 32'd0);
    chk("rst_inst", I_INST, 32'd0);
    chk("rst_req",  32'(MEM_REQ), 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    cyc();
    RST = 1'b1;
    #1;

    // Streaming with 1-cycle memory
    chk("t1_c0_req",  32'(MEM_REQ), 32'd1);
    chk("t1_c0_addr", MEM_ADDR, 32'd0);
    chk("t1_c0_vld",  32'(I_VALID), 32'd0);
    cyc();
    chk("t1_c1_vld",  32'(I_VALID), 32'd0);
    chk("t1_c1_addr", MEM_ADDR, 32'd4);
    cyc();
    chk("t1_c2_vld",  32'(I_VALID), 32'd1);
    chk("t1_c2_pc",   I_PC, 32'd0);
    chk("t1_c2_inst", I_INST, KEY);
    chk_seq("t1_seq", 6, 32'd0);

    // Stall for three cycles while the buffer fills
    do_reset();
    cyc();
    cyc();
    STALL = 1'b1;
    #1;
    chk("t2_c2_vld",  32'(I_VALID), 32'd1);
    chk("t2_c2_pc",   I_PC, 32'd0);
    chk("t2_c2_req",  32'(MEM_REQ), 32'd0);
    cyc();
    chk("t2_c3_pc",   I_PC, 32'd0);
    chk("t2_c3_inst", I_INST, KEY);
    chk("t2_c3_req",  32'(MEM_REQ), 32'd0);
    cyc();
    chk("t2_c4_pc",   I_PC, 32'd0);
    chk("t2_c4_req",  32'(MEM_REQ), 32'd0);
    cyc();
    STALL = 1'b0;
    #1;
    chk("t2_c5_pc",   I_PC, 32'd0);
    chk("t2_c5_req",  32'(MEM_REQ), 32'd0);
    cyc();
    chk("t2_c6_pc",   I_PC, 32'd4);
    chk("t2_c6_req",  32'(MEM_REQ), 32'd1);
    chk("t2_c6_addr", MEM_ADDR, 32'd8);
    chk_seq("t2_seq", 5, 32'd0);

    // Redirect with reads to 8 and 12 outstanding
    rsp_en = 1'b0;
    do_reset();
    BR_TAKEN = 1'b1;
    BR_ADDR  = 32'h0000_0008;
    #1;
    chk("t3_c0_req",  32'(MEM_REQ), 32'd0);
    cyc();
    BR_TAKEN = 1'b0;
    #1;
    chk("t3_c1_req",  32'(MEM_REQ), 32'd1);
    chk("t3_c1_addr", MEM_ADDR, 32'h8);
    cyc();
    chk("t3_c2_addr", MEM_ADDR, 32'hC);
    cyc();
    BR_TAKEN = 1'b1;
    BR_ADDR  = 32'h0000_0100;
    #1;
    chk("t3_c3_req",  32'(MEM_REQ), 32'd0);
    cyc();
    BR_TAKEN = 1'b0;
    rsp_en   = 1'b1;
    #1;
    chk("t3_c4_req",  32'(MEM_REQ), 32'd0);
    chk("t3_c4_addr", MEM_ADDR, 32'h100);
    chk("t3_c4_vld",  32'(I_VALID), 32'd0);
    cyc();
    chk("t3_c5_req",  32'(MEM_REQ), 32'd0);
    chk("t3_c5_vld",  32'(I_VALID), 32'd0);
    cyc();
    chk("t3_c6_req",  32'(MEM_REQ), 32'd1);
    chk("t3_c6_addr", MEM_ADDR, 32'h100);
    cyc();
    chk("t3_c7_vld",  32'(I_VALID), 32'd0);
    chk("t3_c7_addr", MEM_ADDR, 32'h104);
    cyc();
    chk("t3_c8_vld",  32'(I_VALID), 32'd1);
    chk("t3_c8_pc",   I_PC, 32'h100);
    chk("t3_c8_inst", I_INST, 32'hA5A5_0100);
    chk_seq("t3_seq", 2, 32'h100);
    chk("t3_acc0", acc_at(0), 32'h8);
    chk("t3_acc1", acc_at(1), 32'hC);
    chk("t3_acc2", acc_at(2), 32'h100);
    chk("t3_acc3", acc_at(3), 32'h104);

    // Misaligned target, redirect coincident with a returning word
    do_reset();
    #1;
    chk("t4_c0_addr", MEM_ADDR, 32'd0);
    cyc();
    BR_TAKEN = 1'b1;
    BR_ADDR  = 32'h0000_0103;
    #1;
    chk("t4_c1_req",  32'(MEM_REQ), 32'd0);
    chk("t4_c1_vld",  32'(I_VALID), 32'd0);
    cyc();
    BR_TAKEN = 1'b0;
    #1;
    chk("t4_c2_vld",  32'(I_VALID), 32'd0);
    chk("t4_c2_req",  32'(MEM_REQ), 32'd1);
    chk("t4_c2_addr", MEM_ADDR, 32'h100);
    cyc();
    chk("t4_c3_vld",  32'(I_VALID), 32'd0);
    chk("t4_c3_addr", MEM_ADDR, 32'h104);
    cyc();
    chk("t4_c4_vld",  32'(I_VALID), 32'd1);
    chk("t4_c4_pc",   I_PC, 32'h100);
    chk("t4_c4_inst", I_INST, 32'hA5A5_0100);
    chk_seq("t4_seq", 3, 32'h100);

    // Memory not ready for four cycles
    MEM_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      #1;
      chk("t5_hold_req",  32'(MEM_REQ), 32'd1);
      chk("t5_hold_addr", MEM_ADDR, 32'd0);
    end
    cyc();
    MEM_READY = 1'b1;
    #1;
    chk("t5_c4_req",  32'(MEM_REQ), 32'd1);
    chk("t5_c4_addr", MEM_ADDR, 32'd0);
    cyc();
    chk("t5_c5_addr", MEM_ADDR, 32'd4);
    chk("t5_c5_vld",  32'(I_VALID), 32'd0);
    cyc();
    chk("t5_c6_vld",  32'(I_VALID), 32'd1);
    chk("t5_c6_pc",   I_PC, 32'd0);
    chk("t5_nacc",    32'(acc_q.size()), 32'd2);
    chk("t5_acc0",    acc_at(0), 32'd0);
    chk("t5_acc1",    acc_at(1), 32'd4);

    // Reset mid-stream once the PC reaches 0x40
    for (int i = 0; i < 200; i++) begin
      if (MEM_ADDR === 32'h40) break;
      cyc();
    end
    chk("t6_reach", MEM_ADDR, 32'h40);
    RST = 1'b0;
    #1;
    chk("t6_rst_req", 32'(MEM_REQ), 32'd0);
    cyc();
    chk("t6_vld",  32'(I_VALID), 32'd0);
    chk("t6_pc",   I_PC, 32'd0);
    chk("t6_inst", I_INST, 32'd0);
    chk("t6_req",  32'(MEM_REQ), 32'd0);
    chk("t6_addr", MEM_ADDR, 32'd0);
    RST = 1'b1;
    acc_q.delete();
    pop_pc.delete();
    pop_inst.delete();
    #1;
    chk("t6_rel_req", 32'(MEM_REQ), 32'd1);
    chk_seq("t6_seq", 3, 32'd0);
    chk("t6_acc0", acc_at(0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
